// File: rtl/keypad_pkg.sv
// Shared types and defaults for the matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, PRESSED, RELEASE_WAIT} state_t;

  typedef enum logic [1:0] {NONE, KEY, MULTI} result_t;

  localparam int DEFAULT_SCAN_DIV       = 100000;
  localparam int DEFAULT_DEBOUNCE_SCANS = 3;

  function automatic int key_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous column sense lines.
// Resets to all ones, i.e. the pulled-up "no key" level.
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks active-low rows, debounces whole-frame results and
// delivers presses over valid/ack. Define KEYPAD_AUTOREPEAT_EN for auto-repeat.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = DEFAULT_SCAN_DIV,
  parameter int DEBOUNCE_SCANS = DEFAULT_DEBOUNCE_SCANS,
`ifdef KEYPAD_AUTOREPEAT_EN
  parameter int REPEAT_SCANS   = 250,
`endif
  localparam int KW            = key_width(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [ROWS-1:0] row_out,
  input  logic [COLS-1:0] col_in,
  output logic            key_valid,
  output logic [KW-1:0]   key_code,
  input  logic            key_ack,
  output logic            key_pressed,
  output logic            key_overrun,
  output state_t          fsm_state
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

  logic [COLS-1:0] col_s;
  logic [CW-1:0]   dwell;
  logic [RW-1:0]   row_idx;
  logic [1:0]      acc_cnt;
  logic [KW-1:0]   acc_code;
  result_t         prev_res;
  logic [KW-1:0]   prev_code;
  logic [DW-1:0]   deb_cnt;
  state_t          state;
  logic [KW-1:0]   held_code;

  logic            sample;
  logic            frame_done;
  logic [1:0]      row_pop;
  int              row_col;
  logic [2:0]      sum;
  logic [1:0]      tot;
  logic [KW-1:0]   cur_code;
  result_t         res;
  logic            same;
  logic [DW-1:0]   deb_next;
  logic            stable;
  logic            hold_same;
  logic            press_evt;
  logic            ack_fire;

  keypad_sync #(.WIDTH(COLS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (col_in),
    .q     (col_s)
  );

  assign sample     = (dwell == CW'(SCAN_DIV - 1));
  assign frame_done = sample && (row_idx == RW'(ROWS - 1));
  assign fsm_state  = state;

  // Count low columns in the current row (saturating at 2) and keep the lowest one.
  always_comb begin
    row_pop = 2'd0;
    row_col = 0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_s[c]) begin
        row_col = c;
        if (row_pop != 2'd2) row_pop = row_pop + 2'd1;
      end
    end
  end

  always_comb begin
    sum       = {1'b0, acc_cnt} + {1'b0, row_pop};
    tot       = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    cur_code  = (acc_cnt == 2'd0) ? KW'(int'(row_idx) * COLS + row_col) : acc_code;
    res       = (tot == 2'd0) ? NONE : ((tot == 2'd1) ? KEY : MULTI);
    same      = (res == prev_res) && ((res != KEY) || (cur_code == prev_code));
    deb_next  = DW'(1);
    if (same) deb_next = (deb_cnt >= DW'(DEBOUNCE_SCANS)) ? deb_cnt : deb_cnt + 1'b1;
    stable    = (deb_next >= DW'(DEBOUNCE_SCANS));
    hold_same = (res == KEY) && (cur_code == held_code);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell     <= '0;
      row_idx   <= '0;
      row_out   <= ~ROWS'(1);
      acc_cnt   <= 2'd0;
      acc_code  <= '0;
      prev_res  <= NONE;
      prev_code <= '0;
      deb_cnt   <= '0;
    end else begin
      dwell <= sample ? '0 : dwell + 1'b1;
      if (sample) begin
        row_out <= {row_out[ROWS-2:0], row_out[ROWS-1]};
        if (frame_done) begin
          row_idx   <= '0;
          acc_cnt   <= 2'd0;
          acc_code  <= '0;
          prev_res  <= res;
          prev_code <= cur_code;
          deb_cnt   <= deb_next;
        end else begin
          row_idx  <= row_idx + 1'b1;
          acc_cnt  <= tot;
          acc_code <= cur_code;
        end
      end
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int PW = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
  logic [PW-1:0] rep_cnt;
  logic          rep_hit;
  assign rep_hit = (rep_cnt == PW'(REPEAT_SCANS - 1));
`endif

  always_comb begin
    press_evt = frame_done && (state == IDLE) && (res == KEY) && stable;
`ifdef KEYPAD_AUTOREPEAT_EN
    if (frame_done && (state == PRESSED) && hold_same && rep_hit) press_evt = 1'b1;
`endif
  end

  // Handshake: key_valid holds with key_code frozen until a cycle samples
  // key_valid && key_ack; that ack cycle retires the key and clears key_overrun.
  assign ack_fire = key_valid && key_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      held_code   <= '0;
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_pressed <= 1'b0;
      key_overrun <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt     <= '0;
`endif
    end else begin
      if (frame_done) begin
        case (state)
          IDLE: begin
            if (res == KEY && stable) begin
              state       <= PRESSED;
              held_code   <= cur_code;
              key_pressed <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt     <= '0;
`endif
            end
          end
          PRESSED: begin
            if (!hold_same) begin
              state <= RELEASE_WAIT;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            else begin
              rep_cnt <= rep_hit ? '0 : rep_cnt + 1'b1;
            end
`endif
          end
          RELEASE_WAIT: begin
            if (hold_same) begin
              state   <= PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt <= '0;
`endif
            end else if (res == NONE && stable) begin
              state       <= IDLE;
              key_pressed <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end

      if (press_evt) begin
        if (key_valid && !key_ack) begin
          key_overrun <= 1'b1;
        end else begin
          key_valid   <= 1'b1;
          key_code    <= cur_code;
          key_overrun <= 1'b0;
        end
      end else if (ack_fire) begin
        key_valid   <= 1'b0;
        key_overrun <= 1'b0;
      end
    end
  end

endmodule
